// File: rtl/seg_display_pkg.sv
// Shared definitions for the segment display arbiter: FSM state encoding,
// the blank digit pattern and the active-low (g..a) hex glyph table.
package seg_display_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module hex_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; every nibble value maps to a defined pattern.
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one four-digit seven-segment display among
// NUM_REQ requesters. A winner holds the display for DWELL cycles, then the
// grant rotates; a holder that drops its request loses the display at once.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (disp7 down to disp5; disp4 always shows).
//
// state | meaning
// IDLE  | no grant, all digits blank
// SHOW  | exactly one grant bit set, dwell counter running
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DWELL   = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [6:0]             disp7,
  output logic [6:0]             disp6,
  output logic [6:0]             disp5,
  output logic [6:0]             disp4
);

  localparam int unsigned        IDX_W      = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [31:0]        DWELL_LAST = 32'(DWELL - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [NUM_REQ-1:0] win_onehot;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;

  logic               holder_live;
  logic               expire;

  // Round-robin search starting just after the last grantee. The previous
  // holder is visited last, so it only keeps the display when nobody else
  // is asking; a dropped holder is excluded because its req is low.
  always_comb begin
    win_idx  = last_q;
    win_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand     = (int'(last_q) + k) % int'(NUM_REQ);
      cand_idx = IDX_W'(cand);
      if (!win_vld && req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign win_onehot  = NUM_REQ'(1) << win_idx;
  assign holder_live = |(req & gnt_q);
  assign expire      = (cnt_q == DWELL_LAST);

  // Next-state logic: a drop and an expiry share the same re-arbitration,
  // so a simultaneous drop+expiry naturally resolves as a drop.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_vld) begin
          state_d = SHOW;
          gnt_d   = win_onehot;
          last_d  = win_idx;
        end
      end
      SHOW: begin
        if (!holder_live || expire) begin
          cnt_d = '0;
          if (win_vld) begin
            gnt_d  = win_onehot;
            last_d = win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt = gnt_q;

  logic [15:0] sel_data;

  // Live data of the currently granted requester; zero when idle.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_q[i]) begin
        sel_data = sel_data | data[16*i +: 16];
      end
    end
  end

  logic [6:0] raw7, raw6, raw5, raw4;

  hex_to_seg7 u_seg7 (.nibble_i(sel_data[15:12]), .seg_o(raw7));
  hex_to_seg7 u_seg6 (.nibble_i(sel_data[11:8]),  .seg_o(raw6));
  hex_to_seg7 u_seg5 (.nibble_i(sel_data[7:4]),   .seg_o(raw5));
  hex_to_seg7 u_seg4 (.nibble_i(sel_data[3:0]),   .seg_o(raw4));

  logic blank7, blank6, blank5;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Blanking chains from the most significant digit; a non-zero nibble
  // stops it so embedded zeros still show.
  assign blank7 = (sel_data[15:12] == 4'h0);
  assign blank6 = blank7 && (sel_data[11:8] == 4'h0);
  assign blank5 = blank6 && (sel_data[7:4] == 4'h0);
`else
  assign blank7 = 1'b0;
  assign blank6 = 1'b0;
  assign blank5 = 1'b0;
`endif

  logic       show_vld;
  logic [6:0] disp7_q, disp6_q, disp5_q, disp4_q;
  logic [6:0] disp7_d, disp6_d, disp5_d, disp4_d;

  assign show_vld = |gnt_q;

  // Digit selection ahead of the output registers.
  always_comb begin
    disp7_d = SEG_BLANK;
    disp6_d = SEG_BLANK;
    disp5_d = SEG_BLANK;
    disp4_d = SEG_BLANK;
    if (show_vld) begin
      disp7_d = blank7 ? SEG_BLANK : raw7;
      disp6_d = blank6 ? SEG_BLANK : raw6;
      disp5_d = blank5 ? SEG_BLANK : raw5;
      disp4_d = raw4;
    end
  end

  // Registered digits: one cycle behind the grant they reflect.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp7_q <= SEG_BLANK;
      disp6_q <= SEG_BLANK;
      disp5_q <= SEG_BLANK;
      disp4_q <= SEG_BLANK;
    end else begin
      disp7_q <= disp7_d;
      disp6_q <= disp6_d;
      disp5_q <= disp5_d;
      disp4_q <= disp4_d;
    end
  end

  assign disp7 = disp7_q;
  assign disp6 = disp6_q;
  assign disp5 = disp5_q;
  assign disp4 = disp4_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=3, DWELL=4.
module tb_seg_display_arbiter;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SX = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [47:0] data;
  logic [2:0]  gnt;
  logic [6:0]  disp7, disp6, disp5, disp4;

  int checks   = 0;
  int failures = 0;

  seg_display_arbiter #(.NUM_REQ(3), .DWELL(4)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data),
    .gnt(gnt), .disp7(disp7), .disp6(disp6), .disp5(disp5), .disp4(disp4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [27:0] exp);
    check(tag, {disp7, disp6, disp5, disp4}, exp);
  endtask

  task automatic check_gnt(input string tag, input logic [2:0] exp);
    check(tag, {25'd0, gnt}, {25'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    tick();
    reset = 1'b0;
  endtask

  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    data  = '0;

    // reset state, then idle with no requests
    tick();
    check_gnt("rst_gnt", 3'b000);
    check_disp("rst_disp", {SX, SX, SX, SX});
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_gnt("idle_gnt", 3'b000);
      check_disp("idle_disp", {SX, SX, SX, SX});
    end

    // single request from requester 1, 2-cycle display latency
    data[31:16] = 16'h12AF;
    req = 3'b010;
    tick();
    check_gnt("first_gnt", 3'b010);
    check_disp("first_disp_blank", {SX, SX, SX, SX});
    tick();
    check_disp("first_disp_12AF", {S1, S2, SA, SF});
    req = 3'b000;
    tick();
    check_gnt("drop_to_idle", 3'b000);
    tick();
    check_disp("idle_again_disp", {SX, SX, SX, SX});

    // all requesting: round robin with 4-cycle dwell
    do_reset();
    data = {16'hCDE0, 16'h789B, 16'h3456};
    req  = 3'b111;
    for (int t = 1; t <= 16; t++) begin
      tick();
      check_gnt("rr_gnt", rr_exp[(t-1)/4]);
      if (t == 2)  check_disp("rr_disp0", {S3, S4, S5, S6});
      if (t == 6)  check_disp("rr_disp1", {S7, S8, S9, SB});
      if (t == 10) check_disp("rr_disp2", {SC, SD, SE, S0});
    end

    // holder 0 drops at dwell count 1 while requester 2 waits
    do_reset();
    req = 3'b101;
    tick();
    check_gnt("drop_hold_c0", 3'b001);
    tick();
    check_gnt("drop_hold_c1", 3'b001);
    req = 3'b100;
    tick();
    check_gnt("drop_switch", 3'b100);
    req = 3'b101;
    tick();
    check_gnt("post_drop_c1", 3'b100);
    tick();
    check_gnt("post_drop_c2", 3'b100);
    tick();
    check_gnt("post_drop_c3", 3'b100);
    tick();
    check_gnt("post_drop_rotate", 3'b001);

    // reset mid-dwell
    do_reset();
    req = 3'b010;
    tick();
    check_gnt("mid_gnt", 3'b010);
    tick();
    check_gnt("mid_gnt_c1", 3'b010);
    reset = 1'b1;
    tick();
    check_gnt("mid_rst_gnt", 3'b000);
    check_disp("mid_rst_disp", {SX, SX, SX, SX});
    reset = 1'b0;
    req   = 3'b011;
    tick();
    check_gnt("after_rst_gnt", 3'b001);
    check_disp("after_rst_disp", {SX, SX, SX, SX});

    // leading zeros, lone holder keeps grant across expiry
    do_reset();
    data[15:0] = 16'h0045;
    req = 3'b001;
    tick();
    check_gnt("lz_gnt", 3'b001);
    tick();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check_disp("lz_0045", {SX, SX, S4, S5});
`else
    check_disp("lz_0045", {S0, S0, S4, S5});
`endif
    data[15:0] = 16'h0000;
    tick();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check_disp("lz_0000", {SX, SX, SX, S0});
`else
    check_disp("lz_0000", {S0, S0, S0, S0});
`endif
    for (int i = 0; i < 6; i++) tick();
    check_gnt("lone_keep", 3'b001);
    req = 3'b000;
    tick();
    check_gnt("lone_drop_idle", 3'b000);
    tick();
    check_disp("lone_drop_disp", {SX, SX, SX, SX});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
